// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage: valid/ready handshake with a one-entry skid buffer; zero ctrl marks a bubble.
// Optional saturating stall counter enabled by defining ELASTIC_PIPE_STALL_CNT_EN.
module elastic_pipe_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef ELASTIC_PIPE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   // State encoding doubles as {skid valid, main valid}.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b11
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_m_data;
   logic [CTRL_W-1:0]   r_m_ctrl;
   logic [DATA_W-1:0]   r_s_data;
   logic [CTRL_W-1:0]   r_s_ctrl;
   logic                w_m_valid;
   logic                w_s_valid;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_load_m_in;
   logic                w_load_m_skid;
   logic                w_load_s_in;
   logic                w_clr_m;
   logic                w_clr_s;

   assign w_m_valid  = r_state[0];
   assign w_s_valid  = r_state[1];
   assign in_ready   = ~w_s_valid;
   assign out_valid  = w_m_valid;
   assign out_data   = r_m_data;
   assign out_ctrl   = w_m_valid ? r_m_ctrl : '0;
   assign w_in_fire  = in_valid & ~w_s_valid;
   assign w_out_fire = w_m_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_load_m_in   = 1'b0;
      w_load_m_skid = 1'b0;
      w_load_s_in   = 1'b0;
      w_clr_m       = 1'b0;
      w_clr_s       = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_load_m_in = 1'b1;
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_in_fire && w_out_fire) begin
               w_load_m_in = 1'b1;
            end else if (w_in_fire) begin
               w_load_s_in = 1'b1;
               w_state_nxt = ST_SKID;
            end else if (w_out_fire) begin
               w_clr_m     = 1'b1;
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (w_out_fire) begin
               w_load_m_skid = 1'b1;
               w_clr_s       = 1'b1;
               w_state_nxt   = ST_FULL;
            end
         end
         default: begin
            w_clr_m     = 1'b1;
            w_clr_s     = 1'b1;
            w_state_nxt = ST_EMPTY;
         end
      endcase
      // Flush overrides everything; a same-cycle out_fire is simply consumed.
      if (flush) begin
         w_load_m_in   = 1'b0;
         w_load_m_skid = 1'b0;
         w_load_s_in   = 1'b0;
         w_clr_m       = 1'b1;
         w_clr_s       = 1'b1;
         w_state_nxt   = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_data <= '0;
         r_m_ctrl <= '0;
      end else if (w_clr_m) begin
         r_m_data <= '0;
         r_m_ctrl <= '0;
      end else if (w_load_m_in) begin
         r_m_data <= in_data;
         r_m_ctrl <= in_ctrl;
      end else if (w_load_m_skid) begin
         r_m_data <= r_s_data;
         r_m_ctrl <= r_s_ctrl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s_data <= '0;
         r_s_ctrl <= '0;
      end else if (w_clr_s) begin
         r_s_data <= '0;
         r_s_ctrl <= '0;
      end else if (w_load_s_in) begin
         r_s_data <= in_data;
         r_s_ctrl <= in_ctrl;
      end
   end

`ifdef ELASTIC_PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Only reset clears the counter; flush deliberately leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_m_valid && !out_ready && !(&r_stall_cnt))
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign stall_cnt = r_stall_cnt;
`else
   logic [CNT_W-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule
